router_fifo_pkt: RTL and testbench

//  Parametrised packet-aware FIFO for one router output port; next generation of the router FIFO.

---
 rtl/router_fifo_pkt.sv | 133 +++++++++++++
 tb/tb_router_fifo_pkt.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/router_fifo_pkt.sv
// ----------------------------------------------------------------------------
// router_fifo_pkt
//   Packet-aware FIFO for one router output port. Each entry holds a data word
//   plus a header tag. On the read side a length counter, loaded from the
//   header's length field, marks the header word (rd_sop) and the final parity
//   word (rd_eop). Occupancy comes from wrap-bit pointers, so all DEPTH entries
//   are usable.
//
// Ports
//   clock         rising-edge clock
//   resetn        asynchronous active-low reset
//   soft_reset    synchronous flush (port timeout), active-high
//   write_enb     write request
//   read_enb      read request
//   lfd_state     data_in is a packet header
//   data_in       write data
//   data_out      registered read data; holds when no read is accepted
//   rd_sop        data_out is a header word (1 cycle)
//   rd_eop        data_out is the last word of a packet (1 cycle)
//   full          count == DEPTH
//   empty         count == 0
//   count         current occupancy, 0..DEPTH
//   overflow_err  1-cycle pulse: write requested while full
//   underflow_err 1-cycle pulse: read requested while empty
// ----------------------------------------------------------------------------
module router_fifo_pkt #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int LEN_LSB    = 2,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int LEN_W     = DATA_WIDTH - LEN_LSB,
    localparam int CNT_W     = LEN_W + 2
) (
    input  logic                  clock,
    input  logic                  resetn,
    input  logic                  soft_reset,
    input  logic                  write_enb,
    input  logic                  read_enb,
    input  logic                  lfd_state,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  rd_sop,
    output logic                  rd_eop,
    output logic                  full,
    output logic                  empty,
    output logic [ADDR_W:0]       count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    // Bit DATA_WIDTH of each entry is the header tag.
    logic [DATA_WIDTH:0] mem [DEPTH];

    logic [ADDR_W:0]     wr_ptr;
    logic [ADDR_W:0]     rd_ptr;
    logic [CNT_W-1:0]    pkt_cnt;
    logic                wr_acc;
    logic                rd_acc;
    logic [DATA_WIDTH:0] rd_word;

    // Words remaining after a header: payload length plus the parity word.
    function automatic logic [CNT_W-1:0] hdr_load(input logic [DATA_WIDTH-1:0] hdr);
        logic [LEN_W-1:0] len;
        len = hdr[DATA_WIDTH-1:LEN_LSB];
        return CNT_W'(len) + CNT_W'(1);
    endfunction

    // The extra wrap bit distinguishes full from empty when the addresses match.
    assign count   = wr_ptr - rd_ptr;
    assign full    = (count == (ADDR_W+1)'(DEPTH));
    assign empty   = (count == '0);

    assign wr_acc  = write_enb & ~full;
    assign rd_acc  = read_enb & ~empty;
    assign rd_word = mem[rd_ptr[ADDR_W-1:0]];

    // Storage is never cleared; a flush only moves the pointers.
    always_ff @(posedge clock) begin
        if (wr_acc && !soft_reset) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pkt_cnt       <= '0;
            data_out      <= '0;
            rd_sop        <= 1'b0;
            rd_eop        <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else if (soft_reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            pkt_cnt       <= '0;
            data_out      <= '0;
            rd_sop        <= 1'b0;
            rd_eop        <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            // Error pulses use pre-edge flags: a read in the same cycle does
            // not make room for a write issued while full.
            overflow_err  <= write_enb & full;
            underflow_err <= read_enb & empty;
            rd_sop        <= 1'b0;
            rd_eop        <= 1'b0;

            if (wr_acc) begin
                wr_ptr <= wr_ptr + (ADDR_W+1)'(1);
            end

            if (rd_acc) begin
                rd_ptr   <= rd_ptr + (ADDR_W+1)'(1);
                data_out <= rd_word[DATA_WIDTH-1:0];
                if (rd_word[DATA_WIDTH]) begin
                    // A header always reloads, truncating any open packet.
                    rd_sop  <= 1'b1;
                    pkt_cnt <= hdr_load(rd_word[DATA_WIDTH-1:0]);
                end else if (pkt_cnt > CNT_W'(1)) begin
                    pkt_cnt <= pkt_cnt - CNT_W'(1);
                end else if (pkt_cnt == CNT_W'(1)) begin
                    rd_eop  <= 1'b1;
                    pkt_cnt <= '0;
                end
                // pkt_cnt == 0 and untagged: orphan word, no flags.
            end
        end
    end

endmodule

// File: tb/tb_router_fifo_pkt.sv
module tb_router_fifo_pkt;

    logic       clock = 1'b0;
    logic       resetn;
    logic       soft_reset;
    logic       write_enb;
    logic       read_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic [7:0] data_out;
    logic       rd_sop;
    logic       rd_eop;
    logic       full;
    logic       empty;
    logic [4:0] count;
    logic       overflow_err;
    logic       underflow_err;

    int checks = 0;
    int errors = 0;

    router_fifo_pkt #(.DATA_WIDTH(8), .DEPTH(16), .LEN_LSB(2)) dut (
        .clock(clock), .resetn(resetn), .soft_reset(soft_reset),
        .write_enb(write_enb), .read_enb(read_enb), .lfd_state(lfd_state),
        .data_in(data_in), .data_out(data_out), .rd_sop(rd_sop), .rd_eop(rd_eop),
        .full(full), .empty(empty), .count(count),
        .overflow_err(overflow_err), .underflow_err(underflow_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       sr, we, re, lfd;
        logic [7:0] din;
        logic [7:0] dout;
        logic       sop, eop, full, empty;
        logic [4:0] cnt;
        logic       ovf, unf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic we, logic re, logic lfd, logic [7:0] din,
                                logic [7:0] dout, logic sop, logic eop,
                                logic [4:0] cnt, logic ovf, logic unf);
        vec_t v;
        v.sr = 1'b0; v.we = we; v.re = re; v.lfd = lfd; v.din = din;
        v.dout = dout; v.sop = sop; v.eop = eop;
        v.full = (cnt == 5'd16); v.empty = (cnt == 5'd0);
        v.cnt = cnt; v.ovf = ovf; v.unf = unf;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [7:0] dout, input logic sop,
                           input logic eop, input logic [4:0] cnt,
                           input logic ovf, input logic unf);
        chk({tag, ".data_out"}, 32'(data_out), 32'(dout));
        chk({tag, ".rd_sop"}, 32'(rd_sop), 32'(sop));
        chk({tag, ".rd_eop"}, 32'(rd_eop), 32'(eop));
        chk({tag, ".count"}, 32'(count), 32'(cnt));
        chk({tag, ".full"}, 32'(full), 32'(cnt == 5'd16));
        chk({tag, ".empty"}, 32'(empty), 32'(cnt == 5'd0));
        chk({tag, ".overflow_err"}, 32'(overflow_err), 32'(ovf));
        chk({tag, ".underflow_err"}, 32'(underflow_err), 32'(unf));
    endtask

    task automatic drive(input logic we, input logic re, input logic lfd, input logic [7:0] din);
        write_enb = we; read_enb = re; lfd_state = lfd; data_in = din;
    endtask

    // Advance one clock and sample 1 time unit after the rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    logic [7:0] exp_q[$];
    logic [7:0] exp_v;

    initial begin
        resetn = 1'b0; soft_reset = 1'b0;
        drive(0, 0, 0, 8'h00);

        // Directed table: packet, underflow, orphan word, len==0, truncation.
        vecs.push_back(mk(1,0,1,8'h0C, 8'h00,0,0, 5'd1, 0,0));
        vecs.push_back(mk(1,0,0,8'h11, 8'h00,0,0, 5'd2, 0,0));
        vecs.push_back(mk(1,0,0,8'h22, 8'h00,0,0, 5'd3, 0,0));
        vecs.push_back(mk(1,0,0,8'h33, 8'h00,0,0, 5'd4, 0,0));
        vecs.push_back(mk(1,0,0,8'h3C, 8'h00,0,0, 5'd5, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h0C,1,0, 5'd4, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h11,0,0, 5'd3, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h22,0,0, 5'd2, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h33,0,0, 5'd1, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h3C,0,1, 5'd0, 0,0));
        vecs.push_back(mk(0,0,0,8'h00, 8'h3C,0,0, 5'd0, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h3C,0,0, 5'd0, 0,1));
        vecs.push_back(mk(0,0,0,8'h00, 8'h3C,0,0, 5'd0, 0,0));
        vecs.push_back(mk(1,1,0,8'h55, 8'h3C,0,0, 5'd1, 0,1));
        vecs.push_back(mk(0,1,0,8'h00, 8'h55,0,0, 5'd0, 0,0));
        vecs.push_back(mk(1,0,1,8'h01, 8'h55,0,0, 5'd1, 0,0));
        vecs.push_back(mk(1,0,0,8'hAA, 8'h55,0,0, 5'd2, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h01,1,0, 5'd1, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'hAA,0,1, 5'd0, 0,0));
        vecs.push_back(mk(1,0,1,8'h08, 8'hAA,0,0, 5'd1, 0,0));
        vecs.push_back(mk(1,0,0,8'h77, 8'hAA,0,0, 5'd2, 0,0));
        vecs.push_back(mk(1,0,1,8'h04, 8'hAA,0,0, 5'd3, 0,0));
        vecs.push_back(mk(1,0,0,8'h66, 8'hAA,0,0, 5'd4, 0,0));
        vecs.push_back(mk(1,0,0,8'h99, 8'hAA,0,0, 5'd5, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h08,1,0, 5'd4, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h77,0,0, 5'd3, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h04,1,0, 5'd2, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h66,0,0, 5'd1, 0,0));
        vecs.push_back(mk(0,1,0,8'h00, 8'h99,0,1, 5'd0, 0,0));

        // Reset state.
        tick();
        chk_all("reset", 8'h00, 0, 0, 5'd0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;
        tick();

        foreach (vecs[i]) begin
            soft_reset = vecs[i].sr;
            drive(vecs[i].we, vecs[i].re, vecs[i].lfd, vecs[i].din);
            tick();
            chk_all($sformatf("vec%0d", i), vecs[i].dout, vecs[i].sop, vecs[i].eop,
                    vecs[i].cnt, vecs[i].ovf, vecs[i].unf);
        end
        drive(0, 0, 0, 8'h00);
        tick();

        // Fill to full, then overflow, then write+read while full.
        for (int i = 0; i < 16; i++) begin
            drive(1, 0, 0, 8'h80 + 8'(i));
            tick();
        end
        chk("fill.count", 32'(count), 32'd16);
        chk("fill.full", 32'(full), 32'd1);
        drive(1, 0, 0, 8'hEE);
        tick();
        chk("ovf.count", 32'(count), 32'd16);
        chk("ovf.pulse", 32'(overflow_err), 32'd1);
        drive(0, 0, 0, 8'h00);
        tick();
        chk("ovf.clear", 32'(overflow_err), 32'd0);
        drive(1, 1, 0, 8'hEF);
        tick();
        chk("ovf_rw.count", 32'(count), 32'd15);
        chk("ovf_rw.pulse", 32'(overflow_err), 32'd1);
        chk("ovf_rw.data", 32'(data_out), 32'h80);
        for (int i = 1; i < 16; i++) begin
            drive(0, 1, 0, 8'h00);
            tick();
            chk($sformatf("drain%0d", i), 32'(data_out), 32'h80 + 32'(i));
        end
        chk("drain.empty", 32'(empty), 32'd1);

        // Steady state at count 8 for 40 cycles; pointers wrap.
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 0, 8'h40 + 8'(i));
            exp_q.push_back(8'h40 + 8'(i));
            tick();
        end
        for (int k = 0; k < 40; k++) begin
            drive(1, 1, 0, 8'h60 + 8'(k));
            exp_q.push_back(8'h60 + 8'(k));
            exp_v = exp_q.pop_front();
            tick();
            chk($sformatf("ss%0d.data", k), 32'(data_out), 32'(exp_v));
            chk($sformatf("ss%0d.count", k), 32'(count), 32'd8);
        end
        for (int i = 0; i < 8; i++) begin
            drive(0, 1, 0, 8'h00);
            exp_v = exp_q.pop_front();
            tick();
            chk($sformatf("ssdrain%0d", i), 32'(data_out), 32'(exp_v));
        end
        chk("ss.empty", 32'(empty), 32'd1);

        // Soft reset during a read of a partly read packet.
        drive(1, 0, 1, 8'h14);
        tick();
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 0, 8'hB0 + 8'(i));
            tick();
        end
        drive(0, 1, 0, 8'h00);
        tick();
        chk_all("sr.pre", 8'h14, 1, 0, 5'd5, 0, 0);
        soft_reset = 1'b1;
        drive(1, 1, 0, 8'hCC);
        tick();
        chk_all("sr.flush", 8'h00, 0, 0, 5'd0, 0, 0);
        soft_reset = 1'b0;
        drive(1, 0, 1, 8'h08); tick();
        drive(1, 0, 0, 8'hA1); tick();
        drive(1, 0, 0, 8'hA2); tick();
        drive(1, 0, 0, 8'hA3); tick();
        chk("sr.refill", 32'(count), 32'd4);
        drive(0, 1, 0, 8'h00); tick();
        chk_all("sr.r0", 8'h08, 1, 0, 5'd3, 0, 0);
        tick();
        chk_all("sr.r1", 8'hA1, 0, 0, 5'd2, 0, 0);
        tick();
        chk_all("sr.r2", 8'hA2, 0, 0, 5'd1, 0, 0);
        tick();
        chk_all("sr.r3", 8'hA3, 0, 1, 5'd0, 0, 0);

        // Asynchronous reset mid-cycle while a packet is open.
        drive(1, 0, 1, 8'h10); tick();
        drive(1, 0, 0, 8'hD1); tick();
        drive(1, 0, 0, 8'hD2); tick();
        drive(0, 1, 0, 8'h00); tick();
        chk_all("ar.pre", 8'h10, 1, 0, 5'd2, 0, 0);
        drive(0, 0, 0, 8'h00);
        #2;
        resetn = 1'b0;
        #1;
        chk_all("ar.now", 8'h00, 0, 0, 5'd0, 0, 0);
        @(negedge clock);
        resetn = 1'b1;
        // A leftover payload word after reset is gone; the next packet is clean.
        drive(1, 0, 1, 8'h00); tick();
        drive(1, 0, 0, 8'hE1); tick();
        drive(0, 1, 0, 8'h00); tick();
        chk_all("ar.r0", 8'h00, 1, 0, 5'd1, 0, 0);
        tick();
        chk_all("ar.r1", 8'hE1, 0, 1, 5'd0, 0, 0);
        drive(0, 0, 0, 8'h00);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
